// File: rtl/ising_run_sched.sv
// Run scheduler for the Ising array: run configuration registers and the
// reset -> anneal -> snapshot sequence, repeated for a programmed number of runs.
module ising_run_sched #(
    parameter logic [23:0] ADDR_BASE = 24'h000001,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        axi_rstn,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        core_rstn,
    output logic        core_en,
    output logic        snap_req,
    input  logic        snap_ack,
    output logic        busy,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_RUN  = 3'd2,
        S_SNAP = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_RSTCYC = 8'h04;
    localparam logic [7:0] OFF_RUNCYC = 8'h08;
    localparam logic [7:0] OFF_NRUNS  = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;
    localparam logic [7:0] OFF_TOTAL  = 8'h14;

    state_t             state, state_n;
    logic [15:0]        rst_cyc_r;
    logic [CNT_W-1:0]   run_cyc_r;
    logic [15:0]        num_runs_r;
    logic [15:0]        rst_sh;
    logic [CNT_W-1:0]   run_sh;
    logic [15:0]        num_sh;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   rst_lim;
    logic [CNT_W-1:0]   run_lim;
    logic [15:0]        runs_done;
    logic [CNT_W-1:0]   total;
    logic               done_f;
    logic               abort_f;
    logic               wr_hit;
    logic               rd_hit;
    logic               ctrl_wr;
    logic               start_go;
    logic               abort_act;
    logic               ack_take;
    logic [31:0]        rd_mux;

    // ---------------- write decode ----------------
    assign wr_hit    = wr_en && (wr_addr[31:8] == ADDR_BASE);
    assign rd_hit    = rd_en && (rd_addr[31:8] == ADDR_BASE);
    assign ctrl_wr   = wr_hit && (wr_addr[7:0] == OFF_CTRL);
    // abort beats start when both bits are set in one write
    assign abort_act = ctrl_wr && wr_data[1] && (state != S_IDLE);
    assign start_go  = ctrl_wr && wr_data[0] && !wr_data[1] && (state == S_IDLE);
    assign ack_take  = (state == S_SNAP) && snap_ack && !abort_act;

    // shadows are clamped to >= 1 at latch time, so limits never underflow
    assign rst_lim = CNT_W'(rst_sh) - CNT_W'(1);
    assign run_lim = run_sh - CNT_W'(1);

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rst_cyc_r  <= 16'd16;
            run_cyc_r  <= CNT_W'(1000);
            num_runs_r <= 16'd1;
        end else if (wr_hit) begin
            case (wr_addr[7:0])
                OFF_RSTCYC: rst_cyc_r  <= wr_data[15:0];
                OFF_RUNCYC: run_cyc_r  <= CNT_W'(wr_data);
                OFF_NRUNS:  num_runs_r <= wr_data[15:0];
                default: ;
            endcase
        end
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start_go) state_n = S_RST;
            S_RST:  if (cnt == rst_lim) state_n = S_RUN;
            S_RUN:  if (cnt == run_lim) state_n = S_SNAP;
            S_SNAP: begin
                if (snap_ack) begin
                    if ((runs_done + 16'd1) == num_sh) state_n = S_DONE;
                    else                               state_n = S_RST;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort_act) state_n = S_IDLE;
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            if (state_n != state)
                cnt <= '0;
            else if (state == S_RST || state == S_RUN)
                cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rst_sh    <= 16'd1;
            run_sh    <= CNT_W'(1);
            num_sh    <= 16'd1;
            runs_done <= '0;
            total     <= '0;
            done_f    <= 1'b0;
            abort_f   <= 1'b0;
        end else if (start_go) begin
            rst_sh    <= (rst_cyc_r  == '0) ? 16'd1     : rst_cyc_r;
            run_sh    <= (run_cyc_r  == '0) ? CNT_W'(1) : run_cyc_r;
            num_sh    <= (num_runs_r == '0) ? 16'd1     : num_runs_r;
            runs_done <= '0;
            total     <= '0;
            done_f    <= 1'b0;
            abort_f   <= 1'b0;
        end else begin
            // abort in RUN still counts its cycle: core_en was high during it
            if (state == S_RUN && total != '1)
                total <= total + CNT_W'(1);
            if (ack_take)
                runs_done <= runs_done + 16'd1;
            if (state_n == S_DONE)
                done_f <= 1'b1;
            if (abort_act) begin
                abort_f <= 1'b1;
                done_f  <= 1'b0;
            end
        end
    end

    // outputs registered from the next state so they reset to their idle-low values
    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            core_rstn <= 1'b0;
            core_en   <= 1'b0;
            snap_req  <= 1'b0;
            busy      <= 1'b0;
            irq       <= 1'b0;
        end else begin
            core_rstn <= (state_n != S_RST);
            core_en   <= (state_n == S_RUN);
            snap_req  <= (state_n == S_SNAP);
            busy      <= (state_n == S_RST) || (state_n == S_RUN) || (state_n == S_SNAP);
            irq       <= (state_n == S_DONE);
        end
    end

    // ---------------- readback ----------------
    always_comb begin
        rd_mux = 32'h0;
        if (rd_hit) begin
            case (rd_addr[7:0])
                OFF_RSTCYC: rd_mux = {16'h0, rst_cyc_r};
                OFF_RUNCYC: rd_mux = 32'(run_cyc_r);
                OFF_NRUNS:  rd_mux = {16'h0, num_runs_r};
                OFF_STATUS: rd_mux = {runs_done, 10'h0, state, abort_f, done_f, busy};
                OFF_TOTAL:  rd_mux = 32'(total);
                default:    rd_mux = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            rd_valid <= 1'b0;
            rd_data  <= 32'h0;
        end else begin
            rd_valid <= rd_en;
            rd_data  <= rd_en ? rd_mux : 32'h0;
        end
    end

endmodule

// File: doc/ising_run_sched.md
Name: ising_run_sched

Overview:
- Run scheduler for the Ising array. Sits between the OCL AXI-L write/read decode and the coupled-cell core.
- Holds run configuration registers and sequences repeated anneal runs: spin reset, then anneal enable for a programmed cycle count, then a snapshot handshake with the core's readout.
- Repeats this for a programmed number of runs, then reports done and raises an interrupt pulse.

Parameters:
- ADDR_BASE, 24'h000001, match value for wr_addr[31:8] / rd_addr[31:8]; other values are not decoded.
- CNT_W, 32, width of the run-cycle counter and the total-cycle counter.

Ports:
- clk  in  1  clock (clk_main_a0 domain)
- axi_rstn  in  1  asynchronous active-low reset
- wr_en  in  1  one-cycle register write strobe (OCL wready)
- wr_addr  in  32  write byte address
- wr_data  in  32  write data
- rd_en  in  1  one-cycle read strobe (OCL arvalid_q)
- rd_addr  in  32  read byte address
- rd_valid  out  1  read data valid, one cycle
- rd_data  out  32  read data
- core_rstn  out  1  spin reset to core, active-low
- core_en  out  1  anneal enable to core
- snap_req  out  1  snapshot request to core readout
- snap_ack  in  1  snapshot captured, one-cycle pulse
- busy  out  1  run sequence in progress
- irq  out  1  one-cycle pulse on sequence completion

Behaviour:
- Reset values: core_rstn=0, core_en=0, snap_req=0, busy=0, irq=0, rd_valid=0, rd_data=0.
- Reset clears all registers and counters and puts the FSM in IDLE.
- Register map. The offset is wr_addr[7:0] / rd_addr[7:0], word aligned.
  - 0x00 CTRL, write-only. Bit0 = start, bit1 = abort. Both self-clear. Reads return 0.
  - 0x04 RST_CYC [15:0], read/write, reset value 16.
  - 0x08 RUN_CYC [CNT_W-1:0], read/write, reset value 1000.
  - 0x0C NUM_RUNS [15:0], read/write, reset value 1.
  - 0x10 STATUS, read-only. [0] busy, [1] done (sticky), [2] aborted (sticky), [5:3] FSM state code, [31:16] runs_completed.
  - 0x14 TOTAL_CYC, read-only. Count of core_en-high cycles since the last start. Saturates at all-ones.
  - Unmapped offsets: writes are dropped, reads return 0.
- Reads: rd_valid and rd_data are registered exactly 1 cycle after rd_en.
- Config writes while busy: accepted into the registers. At start, the FSM copies RST_CYC, RUN_CYC and NUM_RUNS into shadow copies, and the running sequence uses only the shadows. A zero shadow value is treated as 1.
- FSM states and codes: IDLE 0, RST 1, RUN 2, SNAP 3, DONE 4.
  - IDLE: core_rstn=1, core_en=0. A start write moves to RST the next cycle. On that transition: shadows latched, done/aborted/runs_completed/TOTAL_CYC cleared, busy=1.
  - RST: core_rstn=0 for exactly shadow RST_CYC cycles, then RUN.
  - RUN: core_rstn=1, core_en=1 for exactly shadow RUN_CYC cycles, then SNAP. TOTAL_CYC increments each RUN cycle.
  - SNAP: core_en=0, snap_req held high until snap_ack is sampled high. On ack, runs_completed increments. If the new value equals the NUM_RUNS shadow, go to DONE; otherwise go to RST. snap_req drops the cycle after ack.
  - DONE: one cycle. irq=1, done set, busy cleared, then IDLE.
  - No timeout in SNAP: the FSM waits for snap_ack indefinitely. snap_ack outside SNAP is ignored.
- Start while busy is ignored.
- Abort in any non-IDLE state: the next cycle enters IDLE with core_en=0, snap_req=0, core_rstn=1, busy=0, aborted=1, done=0, and no irq. Counters hold their values for readback.
- Abort and start in the same write: abort wins and start is discarded. Abort in IDLE is a no-op.
- snap_ack in the same cycle as an abort: abort wins, and runs_completed does not increment.
- A read and a write in the same cycle are both serviced. The read returns the pre-write value.
- Reset mid-run: all outputs go immediately to their reset values (asynchronous).

Test Plan:
- Reset values: deassert axi_rstn, read 0x04/0x08/0x0C -> 16 / 1000 / 1, with rd_valid exactly 1 cycle after rd_en. core_rstn=0 while in reset.
- Basic run: RST_CYC=3, RUN_CYC=10, NUM_RUNS=2, start, ack each snap_req after 2 cycles.
  - Two RST windows of 3 cycles and two core_en windows of 10 cycles.
  - Single irq pulse.
  - STATUS=0x0002_0002; TOTAL_CYC=20.
- Zero config: RUN_CYC=0, NUM_RUNS=0, RST_CYC=0, start -> 1 reset cycle, 1 enable cycle, 1 snap, done. runs_completed=1.
- Abort mid-RUN: RUN_CYC=100, abort at RUN cycle 40.
  - Next cycle core_en=0 and busy=0.
  - STATUS aborted=1, done=0; TOTAL_CYC=40; no irq.
- Races:
  - Start plus abort in one write while IDLE -> stays IDLE.
  - snap_ack coincident with abort -> runs_completed unchanged.
  - Start while busy -> no effect on counters.
- Shadowing: write RUN_CYC=50 during a run started with RUN_CYC=10 -> the current run uses 10. The next start uses 50, and a readback of 0x08 returns 50.
